vcmd_spi_tx: RTL and testbench
==============================

// Module: vcmd_spi_tx
// PURPOSE
//  Host-side SPI command transmitter for the vcmd link: the sending end of spi + vcmdv2.
//  Takes a command (opcode byte + up to 3 payload bytes) over a valid/ready handshake.
//  Serialises it MSB-first on Sclk/Mosi, framing each byte with its own CSel low window.
//  Used by the on-board test host and by benches in place of hand-written send_byte tasks.
// PARAMETERS
//  HALF_DIV  2  system clocks per Sclk half-period (>=1); Sclk = f(Clk)/(2*HALF_DIV)
//  GAP_CYC   4  system clocks CSel is held high after every byte (>=1)
//  DWIDTH    8  bits per SPI byte
// PORTS
//  Clk       in   1   system clock, all logic on rising edge
//  RstN      in   1   asynchronous, active-low reset
//  CmdData   in   32  command word; byte 3 [31:24] sent first, then [23:16], [15:8], [7:0]
//  CmdLen    in   2   bytes to send minus 1 (0 -> [31:24] only, 3 -> all four)
//  CmdValid  in   1   command present
//  CmdReady  out  1   block idle, can accept; transfer on CmdValid & CmdReady
//  Busy      out  1   high from accept cycle until Done
//  Done      out  1   one-cycle pulse when last byte's gap ends
//  Sclk      out  1   SPI clock, idle low
//  Mosi      out  1   SPI data
//  CSel      out  1   SPI chip select, active low, idle high
// BEHAVIOUR
//  Reset (async, any state): Sclk=0, Mosi=0, CSel=1, CmdReady=1, Busy=0, Done=0; in-flight command dropped.
//  All outputs registered; no combinational path from inputs to outputs.
//  Accept: on handshake cycle latch CmdData/CmdLen; next cycle CmdReady=0, Busy=1, CSel=0.
//  CmdValid while CmdReady=0 is ignored; CmdData may change freely after acceptance.
//  FSM: IDLE -> LOW -> HIGH -> (LOW next bit | TAIL after bit 0) -> GAP -> (LOW next byte | IDLE).
//   LOW  : Sclk=0, Mosi=current bit, CSel=0, HALF_DIV cycles; Mosi changes only on entry to LOW.
//   HIGH : Sclk=1, Mosi held, CSel=0, HALF_DIV cycles; receiver samples on Sclk rising edge.
//   TAIL : Sclk=0, Mosi held, CSel=0, HALF_DIV cycles after bit 0's HIGH.
//   GAP  : Sclk=0, CSel=1, Mosi=0, GAP_CYC cycles; gap follows every byte incl. the last.
//  Bits per byte: DWIDTH, MSB first; byte counter counts 0..CmdLen, bit counter DWIDTH-1..0.
//  Timing: CSel low 17*HALF_DIV cycles per byte (8 bits); byte period 17*HALF_DIV+GAP_CYC.
//  Done: asserted in last GAP cycle of final byte; next cycle IDLE, CmdReady=1, Busy=0.
//  Back-to-back: CmdValid held high gets accepted the cycle after Done (1 idle cycle min).
//  Half-period counter width $clog2(HALF_DIV+1), gap counter $clog2(GAP_CYC+1); both saturate-free, reload on state entry.
//  Sclk never glitches: it toggles only at LOW->HIGH and HIGH->LOW/TAIL transitions.
// STRUCTURE
//  vcmd_defs.vh (shared include): FSM state localparams, vcmd opcode constants
//   (e.g. VCMD_PIXEL_WR = 8'h41), byte-count field width.
//  Sub-module spi_byte_shifter: loads one byte, shifts MSB-first on a shift strobe,
//   presents current bit; FSM, counters and framing stay in vcmd_spi_tx.
// TESTING (HALF_DIV=2, GAP_CYC=4, loop back into spi + vcmdv2)
//  1 CmdData=32'h41C0C0C0, CmdLen=3 -> spi ByteOut 41,C0,C0,C0 in order; Done 152 clks after accept.
//  2 CmdData=32'h41030303 sent right after test 1 (CmdValid held) -> accepted cycle after Done; vcmdv2 AddrOut advances by one.
//  3 CmdLen=0, CmdData=32'hA5xxxxxx -> single CSel window of 34 clks, Mosi at Sclk rises 1,0,1,0,0,1,0,1; Done at 38.
//  4 RstN low mid-bit of byte 2 -> same-cycle CSel=1, Sclk=0, CmdReady=1; no Done; next command sends correctly.
//  5 CmdValid toggled and CmdData changed while Busy -> ignored, transmitted bytes equal latched word.
//  6 Check Sclk high = low = 2 clks, Mosi stable across every rising edge, CSel high >=4 clks between bytes.

Source files
------------

// File: rtl/vcmd_spi_tx_pkg.sv
// Shared types and constants for the vcmd SPI command transmitter.
package vcmd_spi_tx_pkg;

    localparam int unsigned CMD_W  = 32;
    localparam int unsigned LEN_W  = 2;
    localparam int unsigned BYTE_W = 8;

    // vcmd opcodes carried in the first (top) byte of a command word
    localparam logic [BYTE_W-1:0] VCMD_PIXEL_WR = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_TAIL,
        ST_GAP
    } vcmdState_e;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [CMD_W-1:0] data;
    } vcmdCmd_t;

    // Byte idx of a command word in transmit order (0 = [31:24])
    function automatic logic [BYTE_W-1:0] cmdByte(input logic [CMD_W-1:0] data,
                                                  input logic [LEN_W-1:0] idx);
        case (idx)
            2'd0:    return data[31:24];
            2'd1:    return data[23:16];
            2'd2:    return data[15:8];
            default: return data[7:0];
        endcase
    endfunction

endpackage

// File: rtl/vcmd_spi_tx_if.sv
// Command handshake and status bundle between a host and vcmd_spi_tx.
interface vcmd_spi_tx_if;
    import vcmd_spi_tx_pkg::*;

    logic [CMD_W-1:0] CmdData;
    logic [LEN_W-1:0] CmdLen;
    logic             CmdValid;
    logic             CmdReady;
    logic             Busy;
    logic             Done;

    modport master (
        output CmdData, CmdLen, CmdValid,
        input  CmdReady, Busy, Done
    );

    modport slave (
        input  CmdData, CmdLen, CmdValid,
        output CmdReady, Busy, Done
    );

endinterface

// File: rtl/vcmd_spi_tx_byte_shifter.sv
// One-byte MSB-first shift register; BitOut is the bit currently on the wire.
module vcmd_spi_tx_byte_shifter #(
    parameter int unsigned DWIDTH = 8
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              Load,
    input  logic [DWIDTH-1:0] LoadData,
    input  logic              Shift,
    input  logic              Clear,
    output logic              BitOut
);

    logic [DWIDTH-1:0] shReg;

    // Clear idles the line low between bytes; Load wins over Shift
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            shReg <= '0;
        end else if (Clear) begin
            shReg <= '0;
        end else if (Load) begin
            shReg <= LoadData;
        end else if (Shift) begin
            shReg <= {shReg[DWIDTH-2:0], 1'b0};
        end
    end

    assign BitOut = shReg[DWIDTH-1];

endmodule

// File: rtl/vcmd_spi_tx.sv
// Host-side SPI command transmitter: opcode + up to 3 payload bytes, one CSel window per byte.
module vcmd_spi_tx
    import vcmd_spi_tx_pkg::*;
#(
    parameter int unsigned HALF_DIV = 2,
    parameter int unsigned GAP_CYC  = 4,
    parameter int unsigned DWIDTH   = 8
) (
    input  logic          Clk,
    input  logic          RstN,
    vcmd_spi_tx_if.slave  Cmd,
    output logic          Sclk,
    output logic          Mosi,
    output logic          CSel
);

    localparam int unsigned HALF_W = $clog2(HALF_DIV + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_CYC + 1);
    localparam int unsigned BIT_W  = $clog2(DWIDTH);

    localparam logic [HALF_W-1:0] HALF_RELOAD = HALF_W'(HALF_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_RELOAD  = GAP_W'(GAP_CYC - 1);
    localparam logic [BIT_W-1:0]  BIT_TOP     = BIT_W'(DWIDTH - 1);

    vcmdState_e        state, stateNxt;
    logic [HALF_W-1:0] halfCnt, halfNxt;
    logic [GAP_W-1:0]  gapCnt, gapNxt;
    logic [BIT_W-1:0]  bitCnt, bitNxt;
    logic [LEN_W-1:0]  byteCnt, byteNxt;
    vcmdCmd_t          cmdQ, cmdNxt;

    logic              readyQ, busyQ, doneQ;
    logic              readyNxt, busyNxt, doneNxt, sclkNxt, cselNxt;

    logic              shLoad, shShift, shClear;
    logic [DWIDTH-1:0] shLoadData;

    // State, counters, latched command and registered outputs
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state   <= ST_IDLE;
            halfCnt <= '0;
            gapCnt  <= '0;
            bitCnt  <= '0;
            byteCnt <= '0;
            cmdQ    <= '0;
            readyQ  <= 1'b1;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
            Sclk    <= 1'b0;
            CSel    <= 1'b1;
        end else begin
            state   <= stateNxt;
            halfCnt <= halfNxt;
            gapCnt  <= gapNxt;
            bitCnt  <= bitNxt;
            byteCnt <= byteNxt;
            cmdQ    <= cmdNxt;
            readyQ  <= readyNxt;
            busyQ   <= busyNxt;
            doneQ   <= doneNxt;
            Sclk    <= sclkNxt;
            CSel    <= cselNxt;
        end
    end

    // Next-state, counter reloads, shifter strobes and next output values
    always_comb begin
        stateNxt   = state;
        halfNxt    = halfCnt;
        gapNxt     = gapCnt;
        bitNxt     = bitCnt;
        byteNxt    = byteCnt;
        cmdNxt     = cmdQ;
        shLoad     = 1'b0;
        shLoadData = '0;
        shShift    = 1'b0;
        shClear    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (Cmd.CmdValid) begin
                    stateNxt    = ST_LOW;
                    halfNxt     = HALF_RELOAD;
                    bitNxt      = BIT_TOP;
                    byteNxt     = '0;
                    cmdNxt.data = Cmd.CmdData;
                    cmdNxt.len  = Cmd.CmdLen;
                    shLoad      = 1'b1;
                    shLoadData  = DWIDTH'(cmdByte(Cmd.CmdData, LEN_W'(0)));
                end
            end
            ST_LOW: begin
                if (halfCnt == '0) begin
                    stateNxt = ST_HIGH;
                    halfNxt  = HALF_RELOAD;
                end else begin
                    halfNxt = halfCnt - HALF_W'(1);
                end
            end
            ST_HIGH: begin
                if (halfCnt == '0) begin
                    halfNxt = HALF_RELOAD;
                    if (bitCnt == '0) begin
                        stateNxt = ST_TAIL;
                    end else begin
                        stateNxt = ST_LOW;
                        bitNxt   = bitCnt - BIT_W'(1);
                        shShift  = 1'b1;
                    end
                end else begin
                    halfNxt = halfCnt - HALF_W'(1);
                end
            end
            ST_TAIL: begin
                if (halfCnt == '0) begin
                    stateNxt = ST_GAP;
                    gapNxt   = GAP_RELOAD;
                    shClear  = 1'b1;
                end else begin
                    halfNxt = halfCnt - HALF_W'(1);
                end
            end
            ST_GAP: begin
                if (gapCnt == '0) begin
                    if (byteCnt == cmdQ.len) begin
                        stateNxt = ST_IDLE;
                    end else begin
                        stateNxt   = ST_LOW;
                        byteNxt    = byteCnt + LEN_W'(1);
                        halfNxt    = HALF_RELOAD;
                        bitNxt     = BIT_TOP;
                        shLoad     = 1'b1;
                        shLoadData = DWIDTH'(cmdByte(cmdQ.data, byteCnt + LEN_W'(1)));
                    end
                end else begin
                    gapNxt = gapCnt - GAP_W'(1);
                end
            end
            default: begin
                stateNxt = ST_IDLE;
            end
        endcase

        readyNxt = (stateNxt == ST_IDLE);
        busyNxt  = (stateNxt != ST_IDLE);
        sclkNxt  = (stateNxt == ST_HIGH);
        cselNxt  = !((stateNxt == ST_LOW) || (stateNxt == ST_HIGH) || (stateNxt == ST_TAIL));
        doneNxt  = (stateNxt == ST_GAP) && (gapNxt == '0) && (byteCnt == cmdQ.len);
    end

    vcmd_spi_tx_byte_shifter #(
        .DWIDTH (DWIDTH)
    ) uShifter (
        .Clk      (Clk),
        .RstN     (RstN),
        .Load     (shLoad),
        .LoadData (shLoadData),
        .Shift    (shShift),
        .Clear    (shClear),
        .BitOut   (Mosi)
    );

    assign Cmd.CmdReady = readyQ;
    assign Cmd.Busy     = busyQ;
    assign Cmd.Done     = doneQ;

endmodule

// File: tb/tb_vcmd_spi_tx.sv
// Bench for vcmd_spi_tx: SPI line decoder plus command-level reference model.
module tb_vcmd_spi_tx;
    import vcmd_spi_tx_pkg::*;

    localparam int unsigned HALF_DIV = 2;
    localparam int unsigned GAP_CYC  = 4;
    localparam int unsigned WIN      = 17 * HALF_DIV;
    localparam int unsigned BYTE_PER = WIN + GAP_CYC;

    logic Clk = 1'b0;
    logic RstN;
    logic dSclk, dMosi, dCSel;

    vcmd_spi_tx_if cmdIf ();

    vcmd_spi_tx #(
        .HALF_DIV (HALF_DIV),
        .GAP_CYC  (GAP_CYC),
        .DWIDTH   (8)
    ) dut (
        .Clk  (Clk),
        .RstN (RstN),
        .Cmd  (cmdIf),
        .Sclk (dSclk),
        .Mosi (dMosi),
        .CSel (dCSel)
    );

    always #5 Clk = ~Clk;

    int vecCnt = 0;
    int errCnt = 0;

    logic [7:0] expQ[$];
    logic [7:0] rxQ[$];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bytes on the wire, top byte first, CmdLen+1 of them
    task automatic modelPush(input logic [31:0] data, input logic [1:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            expQ.push_back(8'(data >> (24 - 8 * i)));
        end
    endtask

    function automatic int modelLatency(input logic [1:0] len);
        return (int'(len) + 1) * int'(BYTE_PER);
    endfunction

    // SPI receiver and line-timing monitor, sampled on the falling edge
    int   cselLowRun, gapRun, sclkRun, bitN;
    bit   prevSclk, prevCsel, prevMosi, riseMosi, gapValid;
    logic [7:0] acc;

    always @(negedge Clk) begin
        if (!RstN) begin
            cselLowRun = 0;
            gapRun     = 0;
            sclkRun    = 0;
            bitN       = 0;
            acc        = '0;
            prevSclk   = 1'b0;
            prevCsel   = 1'b1;
            prevMosi   = 1'b0;
            riseMosi   = 1'b0;
            gapValid   = 1'b0;
            rxQ.delete();
        end else begin
            if (!dCSel) begin
                if (prevCsel) begin
                    if (gapValid) checkEq("gap_min", 32'(gapRun >= int'(GAP_CYC)), 32'd1);
                    sclkRun    = 1;
                    cselLowRun = 1;
                end else begin
                    cselLowRun++;
                    if (dSclk != prevSclk) begin
                        checkEq(prevSclk ? "sclk_high" : "sclk_low", 32'(sclkRun), 32'(HALF_DIV));
                        sclkRun = 1;
                    end else begin
                        sclkRun++;
                    end
                end
                if (dSclk && !prevSclk) begin
                    checkEq("mosi_setup", 32'(dMosi), 32'(prevMosi));
                    riseMosi = dMosi;
                    acc      = {acc[6:0], dMosi};
                    bitN++;
                    if (bitN == 8) begin
                        rxQ.push_back(acc);
                        bitN = 0;
                    end
                end else if (dSclk) begin
                    checkEq("mosi_hold", 32'(dMosi), 32'(riseMosi));
                end
            end else begin
                if (!prevCsel) begin
                    checkEq("sclk_tail", 32'(sclkRun), 32'(HALF_DIV));
                    checkEq("csel_window", 32'(cselLowRun), 32'(WIN));
                    checkEq("byte_bits", 32'(bitN), 32'd0);
                    checkEq("gap_lines", 32'({dMosi, dSclk}), 32'd0);
                    gapRun   = 1;
                    gapValid = 1'b1;
                end else begin
                    gapRun++;
                end
            end
            prevSclk = dSclk;
            prevCsel = dCSel;
            prevMosi = dMosi;
        end
    end

    // Present a command, wait for the handshake, check the accept response
    task automatic acceptCmd(input logic [31:0] data, input logic [1:0] len, input bit hold);
        int waitCyc = 0;
        cmdIf.CmdData  = data;
        cmdIf.CmdLen   = len;
        cmdIf.CmdValid = 1'b1;
        while (!cmdIf.CmdReady && waitCyc < 200) begin
            @(negedge Clk);
            waitCyc++;
        end
        checkEq("accept_ready", 32'(cmdIf.CmdReady), 32'd1);
        modelPush(data, len);
        @(negedge Clk);
        checkEq("accept_state", 32'({cmdIf.Busy, cmdIf.CmdReady, dCSel}), 32'b100);
        if (!hold) cmdIf.CmdValid = 1'b0;
    endtask

    // Wait for Done counting cycles from the handshake cycle; optionally disturb inputs
    task automatic waitDone(input int expLat, input bit scramble);
        int cyc = 1;
        bit seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (cmdIf.Done) begin
                seen = 1'b1;
                break;
            end
            if (scramble) begin
                cmdIf.CmdData  = $urandom;
                cmdIf.CmdLen   = 2'($urandom_range(0, 3));
                cmdIf.CmdValid = 1'($urandom_range(0, 1));
            end
            @(negedge Clk);
            cyc++;
        end
        if (scramble) cmdIf.CmdValid = 1'b0;
        checkEq("done_seen", 32'(seen), 32'd1);
        checkEq("done_latency", 32'(cyc), 32'(expLat));
        checkEq("busy_at_done", 32'(cmdIf.Busy), 32'd1);
    endtask

    task automatic compareRx();
        checkEq("rx_count", 32'(rxQ.size()), 32'(expQ.size()));
        while (rxQ.size() > 0 && expQ.size() > 0) begin
            checkEq("rx_byte", 32'(rxQ.pop_front()), 32'(expQ.pop_front()));
        end
        rxQ.delete();
        expQ.delete();
    endtask

    task automatic checkIdleAfter();
        @(negedge Clk);
        checkEq("idle_after", 32'({cmdIf.Done, cmdIf.Busy, cmdIf.CmdReady}), 32'b001);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  l;
        bit          scr;
        int          doneHits;

        RstN           = 1'b0;
        cmdIf.CmdData  = '0;
        cmdIf.CmdLen   = '0;
        cmdIf.CmdValid = 1'b0;
        repeat (3) @(negedge Clk);
        checkEq("rst_lines", 32'({dCSel, dSclk, dMosi}), 32'b100);
        checkEq("rst_status", 32'({cmdIf.CmdReady, cmdIf.Busy, cmdIf.Done}), 32'b100);
        RstN = 1'b1;
        repeat (2) @(negedge Clk);

        // Full pixel-write command, then a second one chained with CmdValid held
        acceptCmd({VCMD_PIXEL_WR, 24'hC0C0C0}, 2'd3, 1'b1);
        cmdIf.CmdData = 32'h41030303;
        cmdIf.CmdLen  = 2'd3;
        waitDone(modelLatency(2'd3), 1'b0);
        compareRx();
        @(negedge Clk);
        checkEq("b2b_idle", 32'({cmdIf.Busy, cmdIf.CmdReady}), 32'b01);
        @(negedge Clk);
        checkEq("b2b_accept", 32'({cmdIf.Busy, cmdIf.CmdReady, dCSel}), 32'b100);
        modelPush(32'h41030303, 2'd3);
        cmdIf.CmdValid = 1'b0;
        waitDone(modelLatency(2'd3), 1'b0);
        compareRx();
        checkIdleAfter();

        // Single byte
        acceptCmd({8'hA5, 24'($urandom)}, 2'd0, 1'b0);
        waitDone(modelLatency(2'd0), 1'b0);
        compareRx();
        checkIdleAfter();

        // Inputs disturbed while busy
        acceptCmd(32'h12345678, 2'd2, 1'b0);
        waitDone(modelLatency(2'd2), 1'b1);
        compareRx();
        checkIdleAfter();

        // Reset in the middle of the second byte
        acceptCmd(32'h41C0C0C0, 2'd3, 1'b0);
        repeat (48) @(negedge Clk);
        RstN = 1'b0;
        #1;
        checkEq("mid_rst_lines", 32'({dCSel, dSclk, dMosi}), 32'b100);
        checkEq("mid_rst_status", 32'({cmdIf.CmdReady, cmdIf.Busy, cmdIf.Done}), 32'b100);
        expQ.delete();
        repeat (2) @(negedge Clk);
        RstN = 1'b1;
        doneHits = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (cmdIf.Done) doneHits++;
        end
        checkEq("no_done_after_rst", 32'(doneHits), 32'd0);
        checkEq("rx_after_rst", 32'(rxQ.size()), 32'd0);

        // Randomised commands
        for (int n = 0; n < 12; n++) begin
            d   = $urandom;
            l   = 2'($urandom_range(0, 3));
            scr = 1'($urandom_range(0, 1));
            acceptCmd(d, l, 1'b0);
            waitDone(modelLatency(l), scr);
            compareRx();
            checkIdleAfter();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
